// File: rtl/lsu_if.sv
// Bundle of request, data-memory and response signals around the load/store unit.
// master is the LSU side; slave is the pipeline/memory environment side.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic        rsp_err;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output rsp_valid, rsp_rdata, rsp_rd, rsp_err
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  rsp_valid, rsp_rdata, rsp_rd, rsp_err
    );
endinterface

// File: rtl/lsu_ctrl.sv
// RV32 load/store unit: one aligned word transaction at a time, with store lane
// formatting, load extension and misalignment/illegal-funct3 faulting.
module lsu_ctrl (
    input  logic  clk,
    input  logic  rst_n,
    lsu_if.master bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]  state_q,  state_d;
    logic [31:0] addr_q,   addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        we_q,     we_d;
    logic [3:0]  strb_q,   strb_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [4:0]  rd_q,     rd_d;
    logic        err_q,    err_d;
    logic [31:0] rdata_q,  rdata_d;

    logic        misaligned;
    logic        illegal;
    logic [3:0]  fmt_strb;
    logic [31:0] fmt_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic        capture;

    // Request checks and store formatting work on the live request so they land in one accept cycle.
    always_comb begin
        misaligned = 1'b0;
        case (bus.req_funct3[1:0])
            2'b01:   misaligned = bus.req_addr[0];
            2'b10:   misaligned = |bus.req_addr[1:0];
            default: misaligned = 1'b0;
        endcase
        if (bus.req_we)
            illegal = (bus.req_funct3 >= 3'b011);
        else
            illegal = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);

        fmt_strb  = 4'b1111;
        fmt_wdata = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                fmt_wdata = {4{bus.req_wdata[7:0]}};
                fmt_strb  = 4'b0001 << bus.req_addr[1:0];
            end
            2'b01: begin
                fmt_wdata = {2{bus.req_wdata[15:0]}};
                fmt_strb  = bus.req_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = bus.mem_rdata;
        endcase
    end

    assign capture = ((state_q == S_REQ) && bus.mem_gnt && bus.mem_rvalid) ||
                     ((state_q == S_WAIT) && bus.mem_rvalid);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        we_d     = we_q;
        strb_d   = strb_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    addr_d   = bus.req_addr;
                    funct3_d = bus.req_funct3;
                    we_d     = bus.req_we;
                    strb_d   = bus.req_we ? fmt_strb : 4'b0000;
                    wdata_d  = bus.req_we ? fmt_wdata : 32'd0;
                    rd_d     = bus.req_we ? 5'd0 : bus.req_rd;
                    err_d    = misaligned || illegal;
                    rdata_d  = 32'd0;
                    state_d  = (misaligned || illegal) ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (bus.mem_gnt)
                    state_d = bus.mem_rvalid ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_rvalid)
                    state_d = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
        // Store acknowledges carry no data back to writeback.
        if (capture)
            rdata_d = we_q ? 32'd0 : ld_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'd0;
            funct3_q <= 3'd0;
            we_q     <= 1'b0;
            strb_q   <= 4'd0;
            wdata_q  <= 32'd0;
            rd_q     <= 5'd0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            we_q     <= we_d;
            strb_q   <= strb_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.mem_req   = (state_q == S_REQ);
    assign bus.mem_we    = bus.mem_req && we_q;
    assign bus.mem_addr  = bus.mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus.mem_wstrb = bus.mem_req ? strb_q : 4'd0;
    assign bus.mem_wdata = bus.mem_req ? wdata_q : 32'd0;

    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = bus.rsp_valid ? rdata_q : 32'd0;
    assign bus.rsp_rd    = bus.rsp_valid ? rd_q : 5'd0;
    assign bus.rsp_err   = bus.rsp_valid && err_q;
endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: vector table driven through a small memory
// responder, responses matched against a scoreboard queue, plus a reset-abort sequence.
`timescale 1ns/1ps
module tb_lsu_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lsu_if bus_if ();

    lsu_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        logic        noise;
        logic        exp_err;
        logic [31:0] exp_maddr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic [4:0]  exp_rd;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int          lat;
    } rsp_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];
    rsp_t sb [$];
    int   n_cmp  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, 32'(bus_if.req_ready), 32'd1);
        chk({tag, "_mem_req"}, 32'(bus_if.mem_req), 32'd0);
        chk({tag, "_mem_we"}, 32'(bus_if.mem_we), 32'd0);
        chk({tag, "_mem_addr"}, bus_if.mem_addr, 32'd0);
        chk({tag, "_mem_wstrb"}, 32'(bus_if.mem_wstrb), 32'd0);
        chk({tag, "_mem_wdata"}, bus_if.mem_wdata, 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus_if.rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, bus_if.rsp_rdata, 32'd0);
        chk({tag, "_rsp_rd"}, 32'(bus_if.rsp_rd), 32'd0);
        chk({tag, "_rsp_err"}, 32'(bus_if.rsp_err), 32'd0);
    endtask

    // Called on a falling edge with the DUT idle; returns on the falling edge after rsp_valid.
    task automatic run_vec(input int idx, input vec_t v);
        rsp_t e;
        rsp_t got;
        logic fault;
        logic seen;
        int   lat_exp;
        fault   = v.exp_err;
        lat_exp = fault ? 1 : 2 + v.gnt_dly + v.rv_dly;
        chk("ready_at_accept", 32'(bus_if.req_ready), 32'd1);
        bus_if.req_valid  = 1'b1;
        bus_if.req_we     = v.we;
        bus_if.req_funct3 = v.f3;
        bus_if.req_addr   = v.addr;
        bus_if.req_wdata  = v.wdata;
        bus_if.req_rd     = v.rd;
        e.err   = v.exp_err;
        e.rdata = v.exp_rdata;
        e.rd    = v.exp_rd;
        e.lat   = lat_exp;
        sb.push_back(e);
        @(negedge clk);
        bus_if.req_valid  = 1'b0;
        bus_if.req_we     = 1'($urandom());
        bus_if.req_funct3 = 3'($urandom());
        bus_if.req_addr   = $urandom();
        bus_if.req_wdata  = $urandom();
        bus_if.req_rd     = 5'($urandom());
        seen = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            if (bus_if.rsp_valid) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_miss++;
                    $display("FAIL rsp_unexpected: got rsp_valid expected none");
                end else begin
                    got = sb.pop_front();
                    chk("rsp_err", 32'(bus_if.rsp_err), 32'(got.err));
                    chk("rsp_rdata", bus_if.rsp_rdata, got.rdata);
                    chk("rsp_rd", 32'(bus_if.rsp_rd), 32'(got.rd));
                    chk("rsp_latency", c, got.lat);
                end
                $display("txn %0d: we=%0d f3=%0d addr=%h -> err=%0d rdata=%h rd=%0d at cycle %0d",
                         idx, v.we, v.f3, v.addr, bus_if.rsp_err, bus_if.rsp_rdata, bus_if.rsp_rd, c);
            end else begin
                chk("ready_busy", 32'(bus_if.req_ready), 32'd0);
                chk("mem_req", 32'(bus_if.mem_req), 32'(!fault && (c <= 1 + v.gnt_dly)));
                if (bus_if.mem_req) begin
                    chk("mem_addr", bus_if.mem_addr, v.exp_maddr);
                    chk("mem_we", 32'(bus_if.mem_we), 32'(v.we));
                    chk("mem_wstrb", 32'(bus_if.mem_wstrb), 32'(v.exp_strb));
                    if (v.we)
                        chk("mem_wdata", bus_if.mem_wdata, v.exp_wdata);
                end
            end
            bus_if.mem_gnt    = !fault && (c == 1 + v.gnt_dly);
            bus_if.mem_rvalid = !fault && (c == 1 + v.gnt_dly + v.rv_dly);
            bus_if.mem_rdata  = bus_if.mem_rvalid ? v.rdata : 32'hDEAD_BEEF;
            // Stray rvalid before the grant and during the response cycle must be ignored.
            if (v.noise && !bus_if.mem_rvalid && ((c < 1 + v.gnt_dly) || seen))
                bus_if.mem_rvalid = 1'b1;
            @(negedge clk);
        end
        bus_if.mem_gnt    = 1'b0;
        bus_if.mem_rvalid = 1'b0;
        if (!seen) begin
            n_cmp++;
            n_miss++;
            $display("FAIL rsp_timeout: got no rsp_valid expected one within 40 cycles");
        end
        chk("rsp_single_pulse", 32'(bus_if.rsp_valid), 32'd0);
    endtask

    initial begin
        //            we    f3      addr          wdata         rd     rdata         g  r  nz    err   maddr         strb     wdata         rdata         rd
        vecs[0]  = '{1'b0, 3'b100, 32'h0000_1003, 32'h0,        5'd5,  32'h80FF_1234, 0, 1, 1'b0, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,        32'h0000_0080, 5'd5};
        vecs[1]  = '{1'b0, 3'b000, 32'h0000_1003, 32'h0,        5'd6,  32'h80FF_1234, 1, 2, 1'b1, 1'b0, 32'h0000_1000, 4'b0000, 32'h0,        32'hFFFF_FF80, 5'd6};
        vecs[2]  = '{1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 5'd7,  32'h5555_5555, 0, 1, 1'b0, 1'b0, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0,        5'd0};
        vecs[3]  = '{1'b0, 3'b010, 32'h0000_3001, 32'h0,        5'd8,  32'h0,        0, 0, 1'b0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        5'd8};
        vecs[4]  = '{1'b1, 3'b001, 32'h0000_3001, 32'h7777_8888, 5'd9,  32'h0,        0, 0, 1'b0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        5'd0};
        vecs[5]  = '{1'b0, 3'b010, 32'h0000_4000, 32'h0,        5'd10, 32'hCAFE_F00D, 5, 3, 1'b1, 1'b0, 32'h0000_4000, 4'b0000, 32'h0,        32'hCAFE_F00D, 5'd10};
        vecs[6]  = '{1'b0, 3'b001, 32'h0000_5002, 32'h0,        5'd11, 32'h8001_7FFF, 0, 0, 1'b0, 1'b0, 32'h0000_5000, 4'b0000, 32'h0,        32'hFFFF_8001, 5'd11};
        vecs[7]  = '{1'b0, 3'b101, 32'h0000_5000, 32'h0,        5'd12, 32'h8001_F00F, 2, 0, 1'b1, 1'b0, 32'h0000_5000, 4'b0000, 32'h0,        32'h0000_F00F, 5'd12};
        vecs[8]  = '{1'b0, 3'b000, 32'h0000_6001, 32'h0,        5'd13, 32'h1234_5678, 0, 1, 1'b0, 1'b0, 32'h0000_6000, 4'b0000, 32'h0,        32'h0000_0056, 5'd13};
        vecs[9]  = '{1'b1, 3'b000, 32'h0000_7001, 32'h0000_00A5, 5'd14, 32'h0,        1, 1, 1'b0, 1'b0, 32'h0000_7000, 4'b0010, 32'hA5A5_A5A5, 32'h0,        5'd0};
        vecs[10] = '{1'b1, 3'b010, 32'h0000_7004, 32'h1122_3344, 5'd15, 32'h0,        0, 2, 1'b0, 1'b0, 32'h0000_7004, 4'b1111, 32'h1122_3344, 32'h0,        5'd0};
        vecs[11] = '{1'b0, 3'b011, 32'h0000_8000, 32'h0,        5'd15, 32'h0,        0, 0, 1'b0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        5'd15};
        vecs[12] = '{1'b1, 3'b100, 32'h0000_8000, 32'h0,        5'd16, 32'h0,        0, 0, 1'b0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        5'd0};
        vecs[13] = '{1'b0, 3'b010, 32'h0000_0010, 32'h0,        5'd17, 32'h0BAD_C0DE, 0, 0, 1'b0, 1'b0, 32'h0000_0010, 4'b0000, 32'h0,        32'h0BAD_C0DE, 5'd17};
        vecs[14] = '{1'b1, 3'b010, 32'h0000_0014, 32'hFFEE_DDCC, 5'd18, 32'h0,        0, 0, 1'b0, 1'b0, 32'h0000_0014, 4'b1111, 32'hFFEE_DDCC, 32'h0,        5'd0};
        vecs[15] = '{1'b0, 3'b001, 32'h0000_9001, 32'h0,        5'd19, 32'h0,        0, 0, 1'b0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        5'd19};
        vecs[16] = '{1'b0, 3'b100, 32'h0000_9002, 32'h0,        5'd20, 32'hA1B2_C3D4, 0, 1, 1'b0, 1'b0, 32'h0000_9000, 4'b0000, 32'h0,        32'h0000_00B2, 5'd20};

        rst_n             = 1'b0;
        bus_if.req_valid  = 1'b0;
        bus_if.req_we     = 1'b0;
        bus_if.req_funct3 = 3'd0;
        bus_if.req_addr   = 32'd0;
        bus_if.req_wdata  = 32'd0;
        bus_if.req_rd     = 5'd0;
        bus_if.mem_gnt    = 1'b0;
        bus_if.mem_rvalid = 1'b0;
        bus_if.mem_rdata  = 32'd0;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++)
            run_vec(i, vecs[i]);

        // Reset while waiting for read data, then a stray rvalid after reset.
        bus_if.req_valid  = 1'b1;
        bus_if.req_we     = 1'b0;
        bus_if.req_funct3 = 3'b010;
        bus_if.req_addr   = 32'h0000_0020;
        bus_if.req_rd     = 5'd3;
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        chk("abort_mem_req", 32'(bus_if.mem_req), 32'd1);
        bus_if.mem_gnt = 1'b1;
        @(negedge clk);
        bus_if.mem_gnt = 1'b0;
        chk("abort_wait_mem_req", 32'(bus_if.mem_req), 32'd0);
        chk("abort_wait_ready", 32'(bus_if.req_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1 chk_idle_outputs("abort");
        @(negedge clk);
        rst_n             = 1'b1;
        bus_if.mem_rvalid = 1'b1;
        bus_if.mem_rdata  = 32'h1234_5678;
        @(negedge clk);
        bus_if.mem_rvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("post_abort_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
            chk("post_abort_ready", 32'(bus_if.req_ready), 32'd1);
            @(negedge clk);
        end
        $display("txn abort: reset during WAIT, stray rvalid ignored");

        // A recovered unit still completes a normal load.
        run_vec(NVEC, vecs[0]);

        n_cmp++;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit for the single-issue RV32 core. It sits directly downstream of the ALU: it takes the effective address produced by the ALU's first adder (rs1 + imm) together with rs2 data and funct3. It then runs one aligned word-wide transaction on the data-memory port and returns sign/zero-extended load data, or a misalignment error, to writeback. One request is outstanding at a time; the block drives the pipeline stall through `req_ready`.

## Interface
- No parameters; the datapath is fixed at 32 bits, with a 4-byte strobe.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: execute stage presents a memory op.
- `req_ready` out 1: high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32 width/sign code. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `req_addr` in 32: effective byte address (ALU adder output).
- `req_wdata` in 32: rs2 value.
- `req_rd` in 5: destination register tag.
- `mem_req` out 1: memory request.
- `mem_we` out 1: write enable.
- `mem_addr` out 32: word address, bits [1:0] always 0.
- `mem_wstrb` out 4: byte enables; 0000 for loads.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_gnt` in 1: memory accepted the request.
- `mem_rvalid` in 1: read data or write acknowledge.
- `mem_rdata` in 32: read word.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_rd` out 5: `req_rd` for loads; 0 for stores.
- `rsp_err` out 1: misaligned access or illegal funct3.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch the request and run the check.
  - Misaligned if: H with addr[0]=1, or W with addr[1:0]≠00.
  - Illegal if: funct3 is 011/110/111 for a load, or ≥011 for a store.
  - Either fault goes to RESP with err=1. Otherwise go to REQ.
- REQ: `mem_req`=1. Addr, we, strb and wdata are held stable until `mem_gnt`.
  - `mem_gnt` alone → WAIT.
  - `mem_gnt` and `mem_rvalid` in the same cycle → RESP, capturing rdata.
- WAIT: on `mem_rvalid`, capture `mem_rdata` and go to RESP.
- RESP: `rsp_valid`=1 for exactly one cycle, then IDLE.
- `mem_rvalid` in IDLE or RESP, or in REQ without `mem_gnt`, is ignored.
- Store formatting:
  - SB: wdata = {4{b}}, strb = 0001 << addr[1:0].
  - SH: wdata = {2{h}}, strb = 0011 << (2·addr[1]).
  - SW: wdata unchanged, strb = 1111.
- Load extraction:
  - Byte lane is selected by the latched addr[1:0]; halfword by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- `rsp_err`=1 forces `rsp_rdata`=0. `rsp_rd` stays `req_rd` on a faulted load and is 0 on a faulted store.

## Timing
- Reset values: state IDLE, `req_ready`=1, and every other output 0.
- Reset is asynchronous and aborts any transaction. A late `mem_rvalid` after reset lands in IDLE and is ignored.
- All outputs are registered or decoded from registered state only. No combinational path exists from `mem_*` inputs to `mem_*` outputs.
- Best case: accept at cycle 0, `mem_req` at cycle 1 with `mem_gnt`, `mem_rvalid` at cycle 2, `rsp_valid` at cycle 3.
- Same-cycle gnt+rvalid: `rsp_valid` at cycle 2.
- Fault path: accept at cycle 0, `rsp_valid`+`rsp_err` at cycle 1; `mem_req` is never asserted.
- `mem_req` drops in the cycle after `mem_gnt`. Gnt and rvalid stalls of any length are tolerated with no timeout.
- The next request can be accepted in the cycle after `rsp_valid`.

## Test plan
- LBU addr 0x1003, `mem_rdata` 0x80FF_1234 → `mem_addr` 0x1000, strb 0000; `rsp_rdata` 0x0000_0080. The same access as LB gives 0xFFFF_FF80.
- SH addr 0x2002, wdata 0x1234_ABCD → `mem_wdata` 0xABCD_ABCD, strb 1100, `mem_we`=1; `rsp_valid` with rdata 0 and rd 0.
- LW addr 0x3001 → `rsp_valid`+`rsp_err` one cycle after accept, `mem_req` stays 0, rdata 0. SH addr 0x3001 behaves the same.
- LW with `mem_gnt` held low 5 cycles, then rvalid 3 cycles after gnt → `mem_addr`/`mem_we` stable throughout; `req_ready` stays 0; exactly one `rsp_valid`.
- `rst_n` pulsed low while in WAIT, followed by a stray `mem_rvalid` → all outputs 0, `req_ready`=1, no `rsp_valid`.
- Back-to-back LW 0x10 then SW 0x14 with zero-latency memory (gnt+rvalid same cycle) → responses 2 cycles after each accept; second accept in the cycle after the first `rsp_valid`.
